uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one uart transmitter among NREQ requesters using round-robin
//   arbitration. Latches the winner's byte and drives the uart transmit strobe.
//   Tracks is_transmitting through start and end, then reports completion to
//   the owning requester. Sits between board-level byte sources (buttons,
//   counters, echo logic) and the uart instance.
// PARAMETERS
//   NREQ     4   number of requesters, 2..8
//   TIMEOUT  16  cycles to wait for is_transmitting to rise (UART_ARB_TIMEOUT_EN only)
// PORTS
//   clk                  in   1       master clock
//   nrst                 in   1       asynchronous active-low reset
//   req                  in   NREQ    per-requester transmit request, level
//   req_byte             in   8*NREQ  byte i at [8*i+7:8*i]
//   gnt                  out  NREQ    one-hot, 1-cycle pulse: byte of requester i accepted
//   done                 out  NREQ    one-hot, 1-cycle pulse: byte of requester i sent
//   busy                 out  1       high whenever state != IDLE
//   uart_transmit        out  1       to uart transmit
//   uart_tx_byte         out  8       to uart tx_byte
//   uart_is_transmitting in   1       from uart is_transmitting
//   err_timeout          out  1       1-cycle pulse on start timeout (UART_ARB_TIMEOUT_EN only)
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset (async, nrst=0) sets:
//     - state=IDLE
//     - gnt, done, uart_transmit, err_timeout = 0
//     - uart_tx_byte = 8'h00
//     - last = NREQ-1, so req[0] has first priority
//   - Reset mid-frame aborts silently. No done pulse is issued, even if the
//     uart keeps shifting.
//   - States are IDLE, START and BUSY.
//   - IDLE:
//     - If req != 0, the winner w is the first set bit searching from last+1
//       upward, wrapping modulo NREQ.
//     - On that edge: uart_tx_byte <= byte w, uart_transmit <= 1,
//       gnt[w] <= 1, owner <= w, state <= START.
//     - gnt is visible one cycle after req is sampled.
//   - START:
//     - uart_transmit stays high until uart_is_transmitting is sampled 1.
//     - On that edge: uart_transmit <= 0, state <= BUSY.
//   - BUSY:
//     - When uart_is_transmitting is sampled 0: done[owner] <= 1,
//       last <= owner, state <= IDLE.
//   - uart_tx_byte is held stable from the launch edge until the done edge.
//   - req and req_byte are ignored outside IDLE.
//   - A requester holding req high after done competes again. Round-robin
//     gives every other pending requester priority first.
//   - A lone requester gets back-to-back service: done -> 1 IDLE cycle ->
//     gnt again.
//   - gnt and done are never high in the same cycle.
//   - At most one bit of gnt, and at most one bit of done, is high at a time.
//   - Pointer width is clog2(NREQ).
//   - Search index arithmetic wraps at NREQ. It does not wrap at 2**width.
// CONFIGURATION
//   Macro UART_ARB_TIMEOUT_EN. With it defined:
//     - A start counter clears on entry to START and increments each START cycle.
//     - If it reaches TIMEOUT-1 with uart_is_transmitting still 0:
//       uart_transmit <= 0, err_timeout <= 1 (1 cycle), done[owner] <= 1,
//       last <= owner, state <= IDLE.
//     - An is_transmitting rise on the same edge takes priority over the
//       timeout.
//   Without it:
//     - START waits indefinitely.
//     - err_timeout is tied 0.
//     - TIMEOUT is unused.
// TESTING
//   1. Reset, then req=4'b0001, byte0=8'hCC; stub uart raises is_transmitting
//      2 cycles after transmit and holds it 10 cycles
//      -> gnt=0001 one cycle later; uart_tx_byte=CC; transmit falls after the
//         rise; done=0001 once is_transmitting falls.
//   2. req=4'b1111 held, bytes 11/22/33/44
//      -> service order 0,1,2,3,0; each gnt/done pair one-hot; tx_byte
//         matches the owner's byte.
//   3. Only req[2] held continuously
//      -> back-to-back frames on requester 2, exactly 1 IDLE cycle between
//         done and the next gnt.
//   4. nrst pulsed low during BUSY
//      -> outputs 0 immediately (async); no done pulse; next arbitration
//         starts at requester 0.
//   5. req[1] toggled while BUSY for requester 0
//      -> no gnt until IDLE; req_byte changes do not disturb uart_tx_byte.
//   6. UART_ARB_TIMEOUT_EN defined, TIMEOUT=16, stub never raises
//      is_transmitting
//      -> 16 cycles after gnt: err_timeout and done[owner] pulse together,
//         transmit=0, busy=0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Requester/uart-side bus of uart_tx_arbiter: request and byte lanes, grant and
// completion pulses, and the uart transmit handshake.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4
) ();
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] req_byte;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   done;
   logic              busy;
   logic              uart_transmit;
   logic [7:0]        uart_tx_byte;
   logic              uart_is_transmitting;
   logic              err_timeout;

   // Arbiter side
   modport slave (
      input  req,
      input  req_byte,
      input  uart_is_transmitting,
      output gnt,
      output done,
      output busy,
      output uart_transmit,
      output uart_tx_byte,
      output err_timeout
   );

   // Requesters plus uart side
   modport master (
      output req,
      output req_byte,
      output uart_is_transmitting,
      input  gnt,
      input  done,
      input  busy,
      input  uart_transmit,
      input  uart_tx_byte,
      input  err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart transmitter among NREQ byte sources.
// Optional start timeout is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16
) (
   input logic               clk,
   input logic               nrst,
   uart_tx_arbiter_if.slave  bus
);
   localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int PW1 = PW + 1;
   localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_BUSY  = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PW-1:0]   r_last;
   logic [PW-1:0]   r_owner;
   logic [PW-1:0]   w_last_nxt;
   logic [PW-1:0]   w_owner_nxt;
   logic [PW-1:0]   w_win;
   logic            w_found;
   logic            w_pick;
   logic [PW:0]     w_idx;
   logic [NREQ-1:0] w_req_sh;
   logic [7:0]      w_win_byte;
   logic            w_timeout;

   logic [NREQ-1:0] r_gnt;
   logic [NREQ-1:0] r_done;
   logic            r_busy;
   logic            r_transmit;
   logic [7:0]      r_tx_byte;
   logic            r_err;
   logic [NREQ-1:0] w_gnt_nxt;
   logic [NREQ-1:0] w_done_nxt;
   logic            w_transmit_nxt;
   logic [7:0]      w_tx_byte_nxt;
   logic            w_err_nxt;

   // Winner search: first request above last, wrapping modulo NREQ (not 2**PW)
   always_comb begin
      w_found  = 1'b0;
      w_win    = '0;
      w_idx    = '0;
      w_req_sh = '0;
      w_pick   = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         w_idx    = {1'b0, r_last} + PW1'(i);
         w_idx    = (w_idx >= PW1'(NREQ)) ? (w_idx - PW1'(NREQ)) : w_idx;
         w_req_sh = bus.req >> w_idx;
         w_pick   = !w_found && w_req_sh[0];
         w_win    = w_pick ? w_idx[PW-1:0] : w_win;
         w_found  = w_found | w_pick;
      end
   end

   assign w_win_byte = bus.req_byte[8*int'(w_win) +: 8];

`ifdef UART_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] r_cnt;

   // Start-wait counter, held at zero outside START
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt <= '0;
      end else if (r_state != ST_START) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign w_timeout = (r_state == ST_START) && !bus.uart_is_transmitting &&
                      (r_cnt == CW'(TIMEOUT - 1));
`else
   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; an is_transmitting rise wins over the timeout
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = w_found ? ST_START : ST_IDLE;
         end
         ST_START: begin
            if (bus.uart_is_transmitting) begin
               w_state_nxt = ST_BUSY;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_START;
            end
         end
         ST_BUSY: begin
            w_state_nxt = bus.uart_is_transmitting ? ST_BUSY : ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output/next-value logic for the registered outputs and bookkeeping
   always_comb begin
      w_gnt_nxt      = '0;
      w_done_nxt     = '0;
      w_err_nxt      = 1'b0;
      w_transmit_nxt = r_transmit;
      w_tx_byte_nxt  = r_tx_byte;
      w_last_nxt     = r_last;
      w_owner_nxt    = r_owner;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_tx_byte_nxt  = w_win_byte;
               w_transmit_nxt = 1'b1;
               w_gnt_nxt      = ONE << w_win;
               w_owner_nxt    = w_win;
            end else begin
               w_transmit_nxt = 1'b0;
            end
         end
         ST_START: begin
            if (bus.uart_is_transmitting) begin
               w_transmit_nxt = 1'b0;
            end else if (w_timeout) begin
               w_transmit_nxt = 1'b0;
               w_err_nxt      = 1'b1;
               w_done_nxt     = ONE << r_owner;
               w_last_nxt     = r_owner;
            end else begin
               w_transmit_nxt = 1'b1;
            end
         end
         ST_BUSY: begin
            if (!bus.uart_is_transmitting) begin
               w_done_nxt = ONE << r_owner;
               w_last_nxt = r_owner;
            end else begin
               w_done_nxt = '0;
            end
         end
         default: begin
            w_transmit_nxt = 1'b0;
         end
      endcase
   end

   // Output and bookkeeping registers; last resets so requester 0 goes first
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_gnt      <= '0;
         r_done     <= '0;
         r_busy     <= 1'b0;
         r_transmit <= 1'b0;
         r_tx_byte  <= 8'h00;
         r_err      <= 1'b0;
         r_last     <= PW'(NREQ - 1);
         r_owner    <= '0;
      end else begin
         r_gnt      <= w_gnt_nxt;
         r_done     <= w_done_nxt;
         r_busy     <= (w_state_nxt != ST_IDLE);
         r_transmit <= w_transmit_nxt;
         r_tx_byte  <= w_tx_byte_nxt;
         r_err      <= w_err_nxt;
         r_last     <= w_last_nxt;
         r_owner    <= w_owner_nxt;
      end
   end

   assign bus.gnt           = r_gnt;
   assign bus.done          = r_done;
   assign bus.busy          = r_busy;
   assign bus.uart_transmit = r_transmit;
   assign bus.uart_tx_byte  = r_tx_byte;
   assign bus.err_timeout   = r_err;
endmodule
